// File: rtl/switch_allocator_np_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// switch_allocator_np_if : request/grant bundle between input buffers and allocator
// Revision 1.0
// ---------------------------------------------------------------------------
interface switch_allocator_np_if #(
  parameter int NUM_PORTS = 5,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) ();
  logic                       en;
  logic [NUM_PORTS-1:0]       in_req;
  logic [NUM_PORTS*IDX_W-1:0] in_dst;
  logic [NUM_PORTS-1:0]       in_tail;
  logic [NUM_PORTS-1:0]       out_ready;
  logic [NUM_PORTS-1:0]       in_gnt;
  logic [NUM_PORTS*IDX_W-1:0] out_sw;
  logic [NUM_PORTS-1:0]       out_vld;

  modport master (
    output en, in_req, in_dst, in_tail, out_ready,
    input  in_gnt, out_sw, out_vld
  );

  modport slave (
    input  en, in_req, in_dst, in_tail, out_ready,
    output in_gnt, out_sw, out_vld
  );
endinterface
`default_nettype wire

// File: rtl/switch_allocator_np.sv
`default_nettype none
// ---------------------------------------------------------------------------
// switch_allocator_np : N-port round-robin wormhole switch allocator, 1-cycle latency
// Revision 1.0
// ---------------------------------------------------------------------------
module switch_allocator_np #(
  parameter int NUM_PORTS = 5,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  switch_allocator_np_if.slave  bus
);

  localparam logic [IDX_W:0] C_NP = (IDX_W+1)'(NUM_PORTS);

  // req_mat[o][i]: input i is asking for output o (out-of-range dst never matches)
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_mat;

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
      assign req_mat[o][i] = bus.in_req[i] &&
                             ({1'b0, bus.in_dst[i*IDX_W +: IDX_W]} == (IDX_W+1)'(o));
    end
  end

  logic [NUM_PORTS-1:0][IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0][IDX_W-1:0] owner_q, owner_d;
  logic [NUM_PORTS-1:0]            lock_q, lock_d;
  logic [NUM_PORTS-1:0]            in_gnt_q, in_gnt_d;
  logic [NUM_PORTS-1:0]            out_vld_q, out_vld_d;
  logic [NUM_PORTS*IDX_W-1:0]      out_sw_q, out_sw_d;

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W:0]   cand;
    logic [IDX_W:0]   nxt;

    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    lock_d    = lock_q;
    in_gnt_d  = '0;
    out_vld_d = '0;
    out_sw_d  = '0;
    found     = 1'b0;
    win       = '0;
    cand      = '0;
    nxt       = '0;

    for (int o = 0; o < NUM_PORTS; o++) begin
      found = 1'b0;
      win   = '0;
      if (bus.en && bus.out_ready[o]) begin
        if (lock_q[o]) begin
          // A locked output waits for its owner even if others are asking
          if (req_mat[o][owner_q[o]]) begin
            found = 1'b1;
            win   = owner_q[o];
          end
        end else begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, rr_ptr_q[o]} + (IDX_W+1)'(k);
            if (cand >= C_NP) begin
              cand = cand - C_NP;
            end
            if (!found && req_mat[o][cand[IDX_W-1:0]]) begin
              found = 1'b1;
              win   = cand[IDX_W-1:0];
            end
          end
        end
      end

      if (found) begin
        out_vld_d[o]                = 1'b1;
        out_sw_d[o*IDX_W +: IDX_W]  = win;
        in_gnt_d[win]               = 1'b1;
        if (bus.in_tail[win]) begin
          lock_d[o] = 1'b0;
          nxt       = {1'b0, win} + (IDX_W+1)'(1);
          if (nxt >= C_NP) begin
            nxt = '0;
          end
          rr_ptr_d[o] = nxt[IDX_W-1:0];
        end else begin
          // Pointer stays put until the tail frees the output
          lock_d[o]  = 1'b1;
          owner_d[o] = win;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      lock_q    <= '0;
      in_gnt_q  <= '0;
      out_vld_q <= '0;
      out_sw_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      in_gnt_q  <= in_gnt_d;
      out_vld_q <= out_vld_d;
      out_sw_q  <= out_sw_d;
    end
  end

  assign bus.in_gnt  = in_gnt_q;
  assign bus.out_vld = out_vld_q;
  assign bus.out_sw  = out_sw_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator_np.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_switch_allocator_np : directed self-checking bench, NUM_PORTS=4
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_switch_allocator_np;
  localparam int NP = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en;
  logic [NP-1:0]    req, tail, ready;
  logic [NP*IW-1:0] dst;
  int checks = 0;
  int errors = 0;

  switch_allocator_np_if #(.NUM_PORTS(NP), .IDX_W(IW)) bus ();

  assign bus.en        = en;
  assign bus.in_req    = req;
  assign bus.in_dst    = dst;
  assign bus.in_tail   = tail;
  assign bus.out_ready = ready;

  switch_allocator_np #(.NUM_PORTS(NP), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic r, input logic [IW-1:0] d, input logic t);
    req[i]          = r;
    dst[i*IW +: IW] = d;
    tail[i]         = t;
  endtask

  task automatic clear_in;
    req  = '0;
    dst  = '0;
    tail = '0;
  endtask

  task automatic test_reset;
    en = 1'b1; ready = 4'b1111; clear_in();
    set_in(1, 1'b1, 2'd2, 1'b1);
    rst = 1'b1;
    step(); step();
    checks++; if (bus.in_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", bus.in_gnt, 4'b0000); end
    checks++; if (bus.out_vld !== 4'b0000) begin errors++; $display("FAIL reset_vld: got %b expected %b", bus.out_vld, 4'b0000); end
    checks++; if (bus.out_sw !== 8'h00) begin errors++; $display("FAIL reset_sw: got %h expected %h", bus.out_sw, 8'h00); end
    clear_in();
    rst = 1'b0;
  endtask

  task automatic test_single;
    set_in(1, 1'b1, 2'd2, 1'b1);
    step();
    checks++; if (bus.out_vld !== 4'b0100) begin errors++; $display("FAIL single_vld: got %b expected %b", bus.out_vld, 4'b0100); end
    checks++; if (bus.out_sw !== 8'h10) begin errors++; $display("FAIL single_sw: got %h expected %h", bus.out_sw, 8'h10); end
    checks++; if (bus.in_gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt: got %b expected %b", bus.in_gnt, 4'b0010); end
    clear_in();
    step();
    checks++; if (bus.out_vld !== 4'b0000) begin errors++; $display("FAIL single_idle: got %b expected %b", bus.out_vld, 4'b0000); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_sw  [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    logic [3:0] exp_gnt [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    set_in(0, 1'b1, 2'd0, 1'b1);
    set_in(1, 1'b1, 2'd0, 1'b1);
    set_in(3, 1'b1, 2'd0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (bus.out_sw[1:0] !== exp_sw[c]) begin errors++; $display("FAIL rr_sw[%0d]: got %0d expected %0d", c, bus.out_sw[1:0], exp_sw[c]); end
      checks++; if (bus.in_gnt !== exp_gnt[c]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, bus.in_gnt, exp_gnt[c]); end
      checks++; if (bus.out_vld !== 4'b0001) begin errors++; $display("FAIL rr_vld[%0d]: got %b expected %b", c, bus.out_vld, 4'b0001); end
    end
    clear_in();
    step();
  endtask

  task automatic test_wormhole;
    // rr_ptr[3]=0, so only the lock keeps input 0 out on the middle flit
    set_in(2, 1'b1, 2'd3, 1'b0);
    step();
    checks++; if (bus.in_gnt !== 4'b0100 || bus.out_sw[7:6] !== 2'd2) begin errors++; $display("FAIL worm_head: gnt %b sw3 %0d expected 0100 2", bus.in_gnt, bus.out_sw[7:6]); end
    set_in(0, 1'b1, 2'd3, 1'b1);
    step();
    checks++; if (bus.in_gnt !== 4'b0100 || bus.out_sw[7:6] !== 2'd2) begin errors++; $display("FAIL worm_body: gnt %b sw3 %0d expected 0100 2", bus.in_gnt, bus.out_sw[7:6]); end
    set_in(2, 1'b1, 2'd3, 1'b1);
    step();
    checks++; if (bus.in_gnt !== 4'b0100 || bus.out_vld !== 4'b1000) begin errors++; $display("FAIL worm_tail: gnt %b vld %b expected 0100 1000", bus.in_gnt, bus.out_vld); end
    set_in(2, 1'b0, 2'd0, 1'b0);
    step();
    checks++; if (bus.in_gnt !== 4'b0001 || bus.out_vld !== 4'b1000 || bus.out_sw !== 8'h00) begin errors++; $display("FAIL worm_next: gnt %b vld %b sw %h expected 0001 1000 00", bus.in_gnt, bus.out_vld, bus.out_sw); end
    clear_in();
    step();
  endtask

  task automatic test_credit_stall;
    set_in(2, 1'b1, 2'd3, 1'b0);
    step();
    checks++; if (bus.in_gnt !== 4'b0100) begin errors++; $display("FAIL stall_head: got %b expected %b", bus.in_gnt, 4'b0100); end
    set_in(0, 1'b1, 2'd3, 1'b1);
    ready = 4'b0111;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (bus.out_vld !== 4'b0000 || bus.in_gnt !== 4'b0000) begin errors++; $display("FAIL stall_cyc[%0d]: vld %b gnt %b expected 0000 0000", c, bus.out_vld, bus.in_gnt); end
    end
    ready = 4'b1111;
    set_in(2, 1'b0, 2'd0, 1'b0);
    step();
    checks++; if (bus.out_vld !== 4'b0000 || bus.in_gnt !== 4'b0000) begin errors++; $display("FAIL stall_lockheld: vld %b gnt %b expected 0000 0000", bus.out_vld, bus.in_gnt); end
    set_in(2, 1'b1, 2'd3, 1'b1);
    step();
    checks++; if (bus.in_gnt !== 4'b0100 || bus.out_sw[7:6] !== 2'd2) begin errors++; $display("FAIL stall_resume: gnt %b sw3 %0d expected 0100 2", bus.in_gnt, bus.out_sw[7:6]); end
    set_in(2, 1'b0, 2'd0, 1'b0);
    step();
    checks++; if (bus.in_gnt !== 4'b0001) begin errors++; $display("FAIL stall_release: got %b expected %b", bus.in_gnt, 4'b0001); end
    clear_in();
    step();
  endtask

  task automatic test_dst_and_enable;
    set_in(1, 1'b1, 2'b11, 1'b1);
    step();
    checks++; if (bus.out_vld !== 4'b1000 || bus.out_sw !== 8'h40 || bus.in_gnt !== 4'b0010) begin errors++; $display("FAIL dst3: vld %b sw %h gnt %b expected 1000 40 0010", bus.out_vld, bus.out_sw, bus.in_gnt); end
    clear_in();
    set_in(0, 1'b1, 2'd0, 1'b1);
    set_in(1, 1'b1, 2'd0, 1'b1);
    en = 1'b0;
    step();
    checks++; if (bus.out_vld !== 4'b0000 || bus.in_gnt !== 4'b0000 || bus.out_sw !== 8'h00) begin errors++; $display("FAIL en_off: vld %b gnt %b sw %h expected 0000 0000 00", bus.out_vld, bus.in_gnt, bus.out_sw); end
    en = 1'b1;
    step();
    checks++; if (bus.in_gnt !== 4'b0010 || bus.out_sw[1:0] !== 2'd1) begin errors++; $display("FAIL en_resume: gnt %b sw0 %0d expected 0010 1", bus.in_gnt, bus.out_sw[1:0]); end
    step();
    checks++; if (bus.in_gnt !== 4'b0001 || bus.out_sw[1:0] !== 2'd0) begin errors++; $display("FAIL en_next: gnt %b sw0 %0d expected 0001 0", bus.in_gnt, bus.out_sw[1:0]); end
    clear_in();
    step();
  endtask

  task automatic test_back_to_back;
    set_in(0, 1'b1, 2'd1, 1'b1);
    set_in(1, 1'b1, 2'd0, 1'b1);
    set_in(2, 1'b1, 2'd3, 1'b1);
    set_in(3, 1'b1, 2'd2, 1'b1);
    step();
    checks++; if (bus.in_gnt !== 4'b1111 || bus.out_vld !== 4'b1111 || bus.out_sw !== 8'hB1) begin errors++; $display("FAIL b2b_a: gnt %b vld %b sw %h expected 1111 1111 b1", bus.in_gnt, bus.out_vld, bus.out_sw); end
    set_in(0, 1'b1, 2'd2, 1'b1);
    set_in(1, 1'b1, 2'd3, 1'b1);
    set_in(2, 1'b1, 2'd0, 1'b1);
    set_in(3, 1'b1, 2'd1, 1'b1);
    step();
    checks++; if (bus.in_gnt !== 4'b1111 || bus.out_sw !== 8'h4E) begin errors++; $display("FAIL b2b_b: gnt %b sw %h expected 1111 4e", bus.in_gnt, bus.out_sw); end
    clear_in();
    step();
  endtask

  task automatic test_async_reset;
    set_in(1, 1'b1, 2'd1, 1'b1);
    step();
    checks++; if (bus.in_gnt !== 4'b0010) begin errors++; $display("FAIL ar_pre: got %b expected %b", bus.in_gnt, 4'b0010); end
    clear_in();
    set_in(2, 1'b1, 2'd1, 1'b0);
    step();
    checks++; if (bus.in_gnt !== 4'b0100 || bus.out_vld !== 4'b0010) begin errors++; $display("FAIL ar_head: gnt %b vld %b expected 0100 0010", bus.in_gnt, bus.out_vld); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.in_gnt !== 4'b0000 || bus.out_vld !== 4'b0000 || bus.out_sw !== 8'h00) begin errors++; $display("FAIL ar_immediate: gnt %b vld %b sw %h expected 0000 0000 00", bus.in_gnt, bus.out_vld, bus.out_sw); end
    #1 rst = 1'b0;
    clear_in();
    set_in(0, 1'b1, 2'd1, 1'b1);
    set_in(3, 1'b1, 2'd1, 1'b1);
    step();
    checks++; if (bus.in_gnt !== 4'b0001 || bus.out_vld !== 4'b0010 || bus.out_sw !== 8'h00) begin errors++; $display("FAIL ar_after: gnt %b vld %b sw %h expected 0001 0010 00", bus.in_gnt, bus.out_vld, bus.out_sw); end
    clear_in();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_dst_and_enable();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
